stall_mem_model: RTL



---
 rtl/stall_mem_model_if.sv | 26 ++
 rtl/stall_mem_model.sv | 134 +++++++++++++
 2 files changed

// File: rtl/stall_mem_model_if.sv
// Request/response bundle between a cache memory port and the stall memory model, plus the write-snoop outputs.
// Latency: none; this file only declares wires.
// Backpressure: requester holds mem_read/mem_write until mem_ready; the snoop side cannot push back.
interface stall_mem_model_if;
    logic        mem_read;
    logic        mem_write;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [29:0] snp_addr;
    logic [31:0] snp_data;
    logic        snp_wen;

    // Requester side: drives requests, observes completion and snoop.
    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, snp_addr, snp_data, snp_wen
    );

    // Memory side: observes requests, drives completion and snoop.
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, snp_addr, snp_data, snp_wen
    );
endinterface

// File: rtl/stall_mem_model.sv
// Word-wide fixed-latency data memory model with a one-cycle write-snoop pulse (snoop enabled by STALL_MEM_SNOOP_EN).
// Latency: request sampled in IDLE at edge T -> mem_ready high for one cycle, LATENCY cycles later.
// Backpressure: one op in flight; requests are ignored while BUSY/DONE, so the requester must hold them until mem_ready.
module stall_mem_model #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input logic              clk,
    input logic              rst,
    stall_mem_model_if.slave bus
);
    localparam int         LP_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] LP_CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_op_wr;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic [31:0] r_mem [0:LP_DEPTH-1];

    logic                  w_req;
    logic                  w_in_idle;
    logic                  w_op_wr;
    logic [29:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_enter_done;

    // With LATENCY=1 the op goes straight from IDLE to DONE, so the live
    // inputs are used on that edge instead of the (not yet loaded) latches.
    assign w_req        = bus.mem_read | bus.mem_write;
    assign w_in_idle    = (r_state == S_IDLE);
    assign w_op_wr      = w_in_idle ? bus.mem_write : r_op_wr;
    assign w_addr       = w_in_idle ? bus.mem_addr  : r_addr;
    assign w_wdata      = w_in_idle ? bus.mem_wdata : r_wdata;
    assign w_idx        = w_addr[DEPTH_LOG2-1:0];
    assign w_enter_done = (w_in_idle && w_req && (LP_CNT_INIT == 8'd0)) ||
                          ((r_state == S_BUSY) && (r_cnt <= 8'd1));

`ifdef STALL_MEM_SNOOP_EN
    logic        r_snp_wen;
    logic [29:0] r_snp_addr;
    logic [31:0] r_snp_data;
`endif

    // FSM, countdown, request latches and registered completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_op_wr    <= 1'b0;
            r_addr     <= 30'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_ready    <= 1'b0;
`ifdef STALL_MEM_SNOOP_EN
            r_snp_wen  <= 1'b0;
            r_snp_addr <= 30'd0;
            r_snp_data <= 32'd0;
`endif
        end else begin
            r_ready <= 1'b0;
`ifdef STALL_MEM_SNOOP_EN
            r_snp_wen <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Write wins when both requests arrive together.
                        r_op_wr <= bus.mem_write;
                        r_addr  <= bus.mem_addr;
                        r_wdata <= bus.mem_wdata;
                        r_cnt   <= LP_CNT_INIT;
                        r_state <= (LP_CNT_INIT == 8'd0) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt <= 8'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_enter_done) begin
                r_ready <= 1'b1;
                if (!w_op_wr) begin
                    r_rdata <= r_mem[w_idx];
                end
`ifdef STALL_MEM_SNOOP_EN
                if (w_op_wr) begin
                    r_snp_wen  <= 1'b1;
                    r_snp_addr <= w_addr;
                    r_snp_data <= w_wdata;
                end
`endif
            end
        end
    end

    // Storage is never cleared; a write lands on the edge entering DONE unless reset is active.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_done && w_op_wr) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign bus.mem_rdata = r_rdata;
    assign bus.mem_ready = r_ready;

`ifdef STALL_MEM_SNOOP_EN
    assign bus.snp_wen  = r_snp_wen;
    assign bus.snp_addr = r_snp_addr;
    assign bus.snp_data = r_snp_data;
`else
    // High address bits only matter for the snoop report, which is absent here.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^w_addr[29:DEPTH_LOG2];
    assign bus.snp_wen  = 1'b0;
    assign bus.snp_addr = 30'd0;
    assign bus.snp_data = 32'd0;
`endif
endmodule
